mem_arbiter: RTL

- Sequences the single unified off-chip memory between I-cache and D-cache miss traffic for the 5-stage 16-bit pipeline.
- Produces the i_rdy and d_rdy stall qualifiers consumed by the decode/hazard logic.
- Handles D-cache dirty-line writeback before its fill.
- Applies D-over-I priority with a starvation guard.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encoding and default widths shared by the memory arbiter and its users.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W     = 14;
    localparam int ARB_LINE_W     = 64;
    localparam int ARB_STARVE_MAX = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_WB = 3'd2,
        D_RD = 3'd3,
        FILL = 3'd4
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences I-cache and D-cache misses onto the single off-chip memory with
// D-over-I priority, dirty-victim writeback ahead of the D fill, and an I starvation guard.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int LINE_W     = ARB_LINE_W,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_dirty,
    input  logic [ADDR_W-1:0] d_wb_addr,
    input  logic [LINE_W-1:0] d_wb_line,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic [LINE_W-1:0] fill_line,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_rdy,
    output logic              d_rdy
);

    localparam int               CNT_W      = $clog2(STARVE_MAX + 2);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    arb_state_e        state_r, state_s;
    logic              mem_re_r, mem_re_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [LINE_W-1:0] mem_wdata_r, mem_wdata_s;
    logic [LINE_W-1:0] fill_line_r, fill_line_s;
    logic              i_fill_we_r, i_fill_we_s;
    logic              d_fill_we_r, d_fill_we_s;
    logic [CNT_W-1:0]  starve_cnt_r, starve_cnt_s;
    logic              grant_d_r, grant_d_s;
    logic [ADDR_W-1:0] d_addr_r, d_addr_s;
    logic              d_win_s;

    // D wins unless an I miss is waiting and D has used up its run of back-to-back grants.
    assign d_win_s = d_miss & (~i_miss | (starve_cnt_r < STARVE_LIM));

    // Next-state, memory request and fill strobe decode.
    always_comb begin
        state_s      = state_r;
        mem_re_s     = mem_re_r;
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        fill_line_s  = fill_line_r;
        i_fill_we_s  = 1'b0;
        d_fill_we_s  = 1'b0;
        starve_cnt_s = starve_cnt_r;
        grant_d_s    = grant_d_r;
        d_addr_s     = d_addr_r;
        case (state_r)
            IDLE: begin
                if (d_win_s) begin
                    grant_d_s = 1'b1;
                    d_addr_s  = d_addr;
                    if (i_miss) begin
                        if (starve_cnt_r == STARVE_LIM) begin
                            starve_cnt_s = STARVE_LIM;
                        end else begin
                            starve_cnt_s = starve_cnt_r + CNT_ONE;
                        end
                    end else begin
                        starve_cnt_s = CNT_ZERO;
                    end
                    if (d_dirty) begin
                        state_s     = D_WB;
                        mem_we_s    = 1'b1;
                        mem_addr_s  = d_wb_addr;
                        mem_wdata_s = d_wb_line;
                    end else begin
                        state_s    = D_RD;
                        mem_re_s   = 1'b1;
                        mem_addr_s = d_addr;
                    end
                end else if (i_miss) begin
                    grant_d_s    = 1'b0;
                    starve_cnt_s = CNT_ZERO;
                    state_s      = I_RD;
                    mem_re_s     = 1'b1;
                    mem_addr_s   = i_addr;
                end else begin
                    state_s = IDLE;
                end
            end
            D_WB: begin
                if (mem_rdy) begin
                    state_s    = D_RD;
                    mem_we_s   = 1'b0;
                    mem_re_s   = 1'b1;
                    mem_addr_s = d_addr_r;
                end else begin
                    state_s = D_WB;
                end
            end
            I_RD, D_RD: begin
                if (mem_rdy) begin
                    state_s     = FILL;
                    mem_re_s    = 1'b0;
                    fill_line_s = mem_rdata;
                    i_fill_we_s = ~grant_d_r;
                    d_fill_we_s = grant_d_r;
                end else begin
                    state_s = state_r;
                end
            end
            FILL: begin
                state_s = IDLE;
            end
            default: begin
                state_s  = IDLE;
                mem_re_s = 1'b0;
                mem_we_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction without a fill strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            mem_re_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {LINE_W{1'b0}};
            fill_line_r  <= {LINE_W{1'b0}};
            i_fill_we_r  <= 1'b0;
            d_fill_we_r  <= 1'b0;
            starve_cnt_r <= CNT_ZERO;
            grant_d_r    <= 1'b0;
            d_addr_r     <= {ADDR_W{1'b0}};
        end else begin
            state_r      <= state_s;
            mem_re_r     <= mem_re_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            fill_line_r  <= fill_line_s;
            i_fill_we_r  <= i_fill_we_s;
            d_fill_we_r  <= d_fill_we_s;
            starve_cnt_r <= starve_cnt_s;
            grant_d_r    <= grant_d_s;
            d_addr_r     <= d_addr_s;
        end
    end

    assign mem_re    = mem_re_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign fill_line = fill_line_r;
    assign i_fill_we = i_fill_we_r;
    assign d_fill_we = d_fill_we_r;
    // The pipeline may proceed in the same cycle the fill lands.
    assign i_rdy     = ~i_miss | i_fill_we_r;
    assign d_rdy     = ~d_miss | d_fill_we_r;

endmodule
